// File: rtl/rv32i_core_pkg.sv
// rv32i_core_pkg: shared decode types, opcode constants and funct3-to-ALU helper.
package rv32i_core_pkg;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef enum logic [1:0] {OP_A_RS1, OP_A_PC, OP_A_ZERO} op_a_sel_e;
    typedef enum logic {OP_B_RS2, OP_B_IMM} op_b_sel_e;
    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;
    typedef enum logic [3:0] {
        ALU_OP_ADD, ALU_OP_SUB, ALU_OP_SLL, ALU_OP_SLT, ALU_OP_SLTU, ALU_OP_XOR,
        ALU_OP_SRL, ALU_OP_SRA, ALU_OP_OR, ALU_OP_AND, ALU_OP_PASS_B
    } alu_op_e;
    typedef enum logic [2:0] {BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU} branch_type_e;
    typedef enum logic [1:0] {MEM_BYTE, MEM_HALF, MEM_WORD} mem_size_e;
    typedef enum logic [1:0] {WB_FROM_NONE, WB_FROM_ALU, WB_FROM_MEM, WB_FROM_PC4} wb_sel_e;

    typedef struct packed {
        logic         valid;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [4:0]   rd;
        op_a_sel_e    op_a_sel;
        op_b_sel_e    op_b_sel;
        imm_type_e    imm_type;
        alu_op_e      alu_op;
        logic         branch;
        branch_type_e branch_type;
        logic         jump;
        logic         jalr;
        logic         mem_read;
        logic         mem_write;
        mem_size_e    mem_size;
        logic         mem_unsigned;
        wb_sel_e      wb_sel;
        logic         reg_write;
    } decode_ctrl_t;

    // Shared funct3 mapping of OP and OP-IMM; SUB/SRA are selected by the caller.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3);
        case (f3)
            3'b000:  alu_from_f3 = ALU_OP_ADD;
            3'b001:  alu_from_f3 = ALU_OP_SLL;
            3'b010:  alu_from_f3 = ALU_OP_SLT;
            3'b011:  alu_from_f3 = ALU_OP_SLTU;
            3'b100:  alu_from_f3 = ALU_OP_XOR;
            3'b101:  alu_from_f3 = ALU_OP_SRL;
            3'b110:  alu_from_f3 = ALU_OP_OR;
            default: alu_from_f3 = ALU_OP_AND;
        endcase
    endfunction
endpackage

// File: rtl/rv32i_decoder.sv
// rv32i_decoder: combinational RV32I decode of one instruction word into a control bundle.
// Any unsupported encoding yields the all-zero bundle, which also drives illegal_o.
module rv32i_decoder
    import rv32i_core_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  instr_i,
    output decode_ctrl_t ctrl_o,
    output logic         illegal_o
);
    decode_ctrl_t w_ctrl;
    logic [6:0]   w_opc;
    logic [2:0]   w_f3;
    logic [6:0]   w_f7;
    logic         w_unused;

    assign w_opc    = instr_i[6:0];
    assign w_f3     = instr_i[14:12];
    assign w_f7     = instr_i[31:25];
    assign w_unused = &{1'b0, clk_i, rst_i};

    always_comb begin
        w_ctrl = '0;
        case (w_opc)
            OPC_LUI, OPC_AUIPC: begin
                w_ctrl.valid     = 1'b1;
                w_ctrl.rd        = instr_i[11:7];
                w_ctrl.op_a_sel  = (w_opc == OPC_LUI) ? OP_A_ZERO : OP_A_PC;
                w_ctrl.op_b_sel  = OP_B_IMM;
                w_ctrl.imm_type  = IMM_U;
                w_ctrl.alu_op    = (w_opc == OPC_LUI) ? ALU_OP_PASS_B : ALU_OP_ADD;
                w_ctrl.wb_sel    = WB_FROM_ALU;
                w_ctrl.reg_write = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                w_ctrl.valid     = (w_opc == OPC_JAL) || (w_f3 == 3'b000);
                w_ctrl.rd        = instr_i[11:7];
                w_ctrl.rs1       = (w_opc == OPC_JALR) ? instr_i[19:15] : 5'd0;
                w_ctrl.jump      = 1'b1;
                w_ctrl.jalr      = (w_opc == OPC_JALR);
                w_ctrl.op_a_sel  = (w_opc == OPC_JALR) ? OP_A_RS1 : OP_A_PC;
                w_ctrl.op_b_sel  = OP_B_IMM;
                w_ctrl.imm_type  = (w_opc == OPC_JALR) ? IMM_I : IMM_J;
                w_ctrl.wb_sel    = WB_FROM_PC4;
                w_ctrl.reg_write = 1'b1;
            end
            OPC_BRANCH: begin
                w_ctrl.valid       = (w_f3[2:1] != 2'b01);
                w_ctrl.rs1         = instr_i[19:15];
                w_ctrl.rs2         = instr_i[24:20];
                w_ctrl.branch      = 1'b1;
                w_ctrl.branch_type = branch_type_e'(w_f3[2] ? {1'b0, w_f3[1:0]} + 3'd2 : {2'b00, w_f3[0]});
                w_ctrl.op_a_sel    = OP_A_PC;
                w_ctrl.op_b_sel    = OP_B_IMM;
                w_ctrl.imm_type    = IMM_B;
            end
            OPC_LOAD, OPC_STORE: begin
                w_ctrl.valid        = (w_f3[1:0] != 2'b11) && ((w_opc == OPC_LOAD) ? w_f3[2:1] != 2'b11 : !w_f3[2]);
                w_ctrl.rs1          = instr_i[19:15];
                w_ctrl.rs2          = (w_opc == OPC_STORE) ? instr_i[24:20] : 5'd0;
                w_ctrl.rd           = (w_opc == OPC_LOAD) ? instr_i[11:7] : 5'd0;
                w_ctrl.mem_read     = (w_opc == OPC_LOAD);
                w_ctrl.mem_write    = (w_opc == OPC_STORE);
                w_ctrl.mem_size     = mem_size_e'(w_f3[1:0]);
                w_ctrl.mem_unsigned = w_f3[2];
                w_ctrl.op_b_sel     = OP_B_IMM;
                w_ctrl.imm_type     = (w_opc == OPC_LOAD) ? IMM_I : IMM_S;
                w_ctrl.wb_sel       = (w_opc == OPC_LOAD) ? WB_FROM_MEM : WB_FROM_NONE;
                w_ctrl.reg_write    = (w_opc == OPC_LOAD);
            end
            OPC_OP_IMM: begin
                w_ctrl.valid     = (w_f3 == 3'b001) ? (w_f7 == 7'b0000000) :
                                   (w_f3 == 3'b101) ? (w_f7 == 7'b0000000 || w_f7 == 7'b0100000) : 1'b1;
                w_ctrl.rs1       = instr_i[19:15];
                w_ctrl.rd        = instr_i[11:7];
                w_ctrl.op_b_sel  = OP_B_IMM;
                w_ctrl.imm_type  = IMM_I;
                w_ctrl.alu_op    = (w_f3 == 3'b101 && w_f7[5]) ? ALU_OP_SRA : alu_from_f3(w_f3);
                w_ctrl.wb_sel    = WB_FROM_ALU;
                w_ctrl.reg_write = 1'b1;
            end
            OPC_OP: begin
                w_ctrl.valid     = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101));
                w_ctrl.rs1       = instr_i[19:15];
                w_ctrl.rs2       = instr_i[24:20];
                w_ctrl.rd        = instr_i[11:7];
                w_ctrl.alu_op    = w_f7[5] ? ((w_f3 == 3'b000) ? ALU_OP_SUB : ALU_OP_SRA) : alu_from_f3(w_f3);
                w_ctrl.wb_sel    = WB_FROM_ALU;
                w_ctrl.reg_write = 1'b1;
            end
            OPC_FENCE: w_ctrl.valid = (w_f3 == 3'b000);
            default: ;
        endcase
        if (!w_ctrl.valid) w_ctrl = '0;
    end

    assign ctrl_o    = w_ctrl;
    assign illegal_o = !w_ctrl.valid;
endmodule

// File: tb/tb_rv32i_decoder.sv
// tb_rv32i_decoder: directed decode vectors with hand-built expected control bundles.
module tb_rv32i_decoder;
    import rv32i_core_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  instr = 32'h0;
    decode_ctrl_t ctrl;
    logic         illegal;
    decode_ctrl_t e;
    int           checks = 0;
    int           failures = 0;

    rv32i_decoder dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .instr_i   (instr),
        .ctrl_o    (ctrl),
        .illegal_o (illegal)
    );

    always #5 clk = ~clk;

    task automatic apply(input logic [31:0] v);
        @(posedge clk);
        #2 instr = v;
        #2;
    endtask

    task automatic check(input string tag, input decode_ctrl_t exp, input logic exp_ill);
        checks++;
        assert (ctrl === exp) else begin
            failures++;
            $error("FAIL %s ctrl observed=%h expected=%h", tag, ctrl, exp);
        end
        checks++;
        assert (illegal === exp_ill) else begin
            failures++;
            $error("FAIL %s illegal observed=%b expected=%b", tag, illegal, exp_ill);
        end
    endtask

    initial begin
        apply(32'h00000000);
        check("zero_in_reset", '0, 1'b1);
        e = '0; e.valid = 1'b1; e.rd = 5'd5; e.op_a_sel = OP_A_ZERO; e.op_b_sel = OP_B_IMM;
        e.imm_type = IMM_U; e.alu_op = ALU_OP_PASS_B; e.wb_sel = WB_FROM_ALU; e.reg_write = 1'b1;
        apply(32'h123452B7);
        check("lui_in_reset", e, 1'b0);
        rst = 1'b0;
        apply(32'h00000000);
        check("zero", '0, 1'b1);
        apply(32'h123452B7);
        check("lui", e, 1'b0);
        e.op_a_sel = OP_A_PC; e.alu_op = ALU_OP_ADD;
        apply(32'h12345297);
        check("auipc", e, 1'b0);
        apply(32'h123452B4);
        check("low_bits", '0, 1'b1);
        e = '0; e.valid = 1'b1; e.rd = 5'd5; e.rs1 = 5'd6; e.jump = 1'b1; e.jalr = 1'b1;
        e.op_b_sel = OP_B_IMM; e.imm_type = IMM_I; e.wb_sel = WB_FROM_PC4; e.reg_write = 1'b1;
        apply(32'h00C302E7);
        check("jalr", e, 1'b0);
        apply(32'h00C312E7);
        check("jalr_f3", '0, 1'b1);
        e = '0; e.valid = 1'b1; e.rd = 5'd1; e.jump = 1'b1; e.op_a_sel = OP_A_PC;
        e.op_b_sel = OP_B_IMM; e.imm_type = IMM_J; e.wb_sel = WB_FROM_PC4; e.reg_write = 1'b1;
        apply(32'h000000EF);
        check("jal", e, 1'b0);
        e = '0; e.valid = 1'b1; e.rs1 = 5'd1; e.rs2 = 5'd2; e.branch = 1'b1; e.branch_type = BR_EQ;
        e.op_a_sel = OP_A_PC; e.op_b_sel = OP_B_IMM; e.imm_type = IMM_B;
        apply(32'h00208063);
        check("beq", e, 1'b0);
        e.branch_type = BR_LTU;
        apply(32'h0020E063);
        check("bltu", e, 1'b0);
        e.branch_type = BR_GE;
        apply(32'h0020D063);
        check("bge", e, 1'b0);
        apply(32'h0020A063);
        check("br_f3_010", '0, 1'b1);
        e = '0; e.valid = 1'b1; e.rs1 = 5'd2; e.rd = 5'd3; e.mem_read = 1'b1; e.mem_size = MEM_WORD;
        e.op_b_sel = OP_B_IMM; e.imm_type = IMM_I; e.wb_sel = WB_FROM_MEM; e.reg_write = 1'b1;
        apply(32'h00012183);
        check("lw", e, 1'b0);
        e.mem_size = MEM_BYTE; e.mem_unsigned = 1'b1;
        apply(32'h00014183);
        check("lbu", e, 1'b0);
        apply(32'h00016183);
        check("load_f3_110", '0, 1'b1);
        e = '0; e.valid = 1'b1; e.rs1 = 5'd2; e.rs2 = 5'd3; e.mem_write = 1'b1; e.mem_size = MEM_WORD;
        e.op_b_sel = OP_B_IMM; e.imm_type = IMM_S;
        apply(32'h00312023);
        check("sw", e, 1'b0);
        apply(32'h00314023);
        check("store_f3_100", '0, 1'b1);
        e = '0; e.valid = 1'b1; e.rs1 = 5'd2; e.rd = 5'd1; e.op_b_sel = OP_B_IMM; e.imm_type = IMM_I;
        e.alu_op = ALU_OP_SRA; e.wb_sel = WB_FROM_ALU; e.reg_write = 1'b1;
        apply(32'h40315093);
        check("srai", e, 1'b0);
        e.alu_op = ALU_OP_SRL;
        apply(32'h00315093);
        check("srli", e, 1'b0);
        apply(32'h40311093);
        check("slli_f7", '0, 1'b1);
        e.alu_op = ALU_OP_SLTU;
        apply(32'h40313093);
        check("sltiu_imm", e, 1'b0);
        e = '0; e.valid = 1'b1; e.rs1 = 5'd12; e.rs2 = 5'd13; e.rd = 5'd11; e.alu_op = ALU_OP_AND;
        e.wb_sel = WB_FROM_ALU; e.reg_write = 1'b1;
        apply(32'h00D675B3);
        check("and", e, 1'b0);
        e.alu_op = ALU_OP_SUB;
        apply(32'h40D605B3);
        check("sub", e, 1'b0);
        apply(32'h40D625B3);
        check("op_f7_20_slt", '0, 1'b1);
        apply(32'h02D605B3);
        check("mul", '0, 1'b1);
        e = '0; e.valid = 1'b1;
        apply(32'h0FF0000F);
        check("fence", e, 1'b0);
        apply(32'h00000073);
        check("ecall", '0, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
